// File: rtl/sfp_pkg.sv
// Shared types and lane helpers for the accumulating SFP array.
// Saturation is classified from the two top bits of a widened sum.
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_e;

  // top = {sum[W], sum[W-1]} of a (W+1)-bit signed sum
  function automatic sat_e sat_add_kind(
    input logic [1:0] top
  );
    sat_e k;
    unique case (top)
      2'b01:   k = SAT_HI;
      2'b10:   k = SAT_LO;
      default: k = SAT_NONE;
    endcase
    return k;
  endfunction

  function automatic logic relu_kill(
    input logic neg,
    input logic en
  );
    return neg & en;
  endfunction

endpackage

// File: rtl/sfp_lane_sat.sv
// One psum lane: overwrite-or-saturating-add on the write side,
// optional ReLU on the drain side.
module sfp_lane_sat
  import sfp_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] acc,
  input  logic [psum_bw-1:0] din,
  input  logic               first,
  input  logic [psum_bw-1:0] rd,
  input  logic               relu,
  output logic [psum_bw-1:0] sum,
  output logic [psum_bw-1:0] q
);

  localparam int W = psum_bw;

  logic [W:0]   wide;
  logic [W-1:0] sat;

  assign wide = {acc[W-1], acc} + {din[W-1], din};

  always_comb begin
    sat = wide[W-1:0];
    unique case (sat_add_kind(wide[W:W-1]))
      SAT_HI:  sat = {1'b0, {(W-1){1'b1}}};
      SAT_LO:  sat = {1'b1, {(W-1){1'b0}}};
      default: sat = wide[W-1:0];
    endcase
  end

  assign sum = first ? din : sat;
  assign q   = relu_kill(rd[W-1], relu) ? '0 : rd;

endmodule

// File: rtl/sfp_acc_array.sv
// Multi-pass psum accumulator: buffers depth pixels of col lanes,
// sums num_acc passes in place, then drains with optional ReLU.
module sfp_acc_array
  import sfp_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int cnt_bw  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [cnt_bw-1:0]          cfg_num_acc,
  input  logic [$clog2(depth):0]     cfg_num_out,
  input  logic                       cfg_relu,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [psum_bw*col-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [psum_bw*col-1:0]     out_data,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(depth);
  localparam int NW = AW + 1;
  localparam int VW = col * psum_bw;
  localparam logic [NW-1:0] DEPTH_N = NW'(depth);

  state_e            state, state_n;
  logic [AW-1:0]     wr_ptr, rd_ptr, last_out;
  logic [cnt_bw-1:0] pass_cnt, last_acc;
  logic              relu_r, done_r, done_n;
  logic [NW-1:0]     num_out;
  logic              beat, fire, first;
  logic              last_px, last_beat, last_rd;

  logic [VW-1:0] mem [depth];
  logic [VW-1:0] wr_word, rd_word;
  logic [VW-1:0] acc_word, drain_word;

  assign num_out =
    (cfg_num_out == '0)     ? NW'(1)  :
    (cfg_num_out > DEPTH_N) ? DEPTH_N :
                              cfg_num_out;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign out_data  = out_valid ? drain_word : '0;

  assign beat      = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign first     = (pass_cnt == '0);
  assign last_px   = (wr_ptr == last_out);
  assign last_beat = last_px && (pass_cnt == last_acc);
  assign last_rd   = (rd_ptr == last_out);

  assign wr_word = mem[wr_ptr];
  assign rd_word = mem[rd_ptr];

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane_sat #(
      .psum_bw(psum_bw)
    ) u_lane (
      .acc  (wr_word[i*psum_bw +: psum_bw]),
      .din  (in_data[i*psum_bw +: psum_bw]),
      .first(first),
      .rd   (rd_word[i*psum_bw +: psum_bw]),
      .relu (relu_r),
      .sum  (acc_word[i*psum_bw +: psum_bw]),
      .q    (drain_word[i*psum_bw +: psum_bw])
    );
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE:    if (start) state_n = ACC;
      ACC:     if (beat && last_beat) state_n = DRAIN;
      DRAIN: begin
        if (fire && last_rd) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done_r   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
      last_out <= '0;
      last_acc <= '0;
      relu_r   <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= done_n;
      if (state == IDLE && start) begin
        last_out <= AW'(num_out - NW'(1));
        last_acc <= (cfg_num_acc == '0) ? '0
                  : cfg_num_acc - cnt_bw'(1);
        relu_r   <= cfg_relu;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        pass_cnt <= '0;
      end
      if (beat) begin
        if (last_beat) begin
          wr_ptr   <= '0;
          pass_cnt <= '0;
          rd_ptr   <= '0;
        end else if (last_px) begin
          wr_ptr   <= '0;
          pass_cnt <= pass_cnt + cnt_bw'(1);
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      if (fire) begin
        rd_ptr <= last_rd ? '0 : rd_ptr + AW'(1);
      end
    end
  end

  // buffer is never reset; pass 0 overwrites each entry
  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr] <= acc_word;
  end

endmodule

// File: tb/tb_sfp_acc_array.sv
// Directed scoreboard bench for sfp_acc_array.
// Stimulus and expected pixels are queued before each job.
module tb_sfp_acc_array;

  localparam int COL   = 8;
  localparam int PB    = 16;
  localparam int DEPTH = 16;
  localparam int CB    = 8;
  localparam int NW    = 5;
  localparam int VW    = COL * PB;

  logic          clk = 1'b0;
  logic          reset, start, cfg_relu;
  logic [CB-1:0] cfg_num_acc;
  logic [NW-1:0] cfg_num_out;
  logic          in_valid, in_ready;
  logic          out_valid, out_ready;
  logic          busy, done;
  logic [VW-1:0] in_data, out_data;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] stim_q[$];
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sfp_acc_array #(
    .col(COL), .psum_bw(PB),
    .depth(DEPTH), .cnt_bw(CB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_num_acc(cfg_num_acc),
    .cfg_num_out(cfg_num_out),
    .cfg_relu   (cfg_relu),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int l = 0; l < COL; l++) r[l*PB +: PB] = PB'(v);
    return r;
  endfunction

  function automatic int clampv(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // integer reference model for random jobs
  task automatic gen_rand(input int na, input int no,
                          input bit relu);
    int m[DEPTH][COL];
    logic [VW-1:0] vec;
    int v;
    for (int p = 0; p < na; p++) begin
      for (int x = 0; x < no; x++) begin
        for (int l = 0; l < COL; l++) begin
          v = int'($urandom_range(2000)) - 1000;
          vec[l*PB +: PB] = PB'(v);
          m[x][l] = (p == 0) ? v : clampv(m[x][l] + v);
        end
        stim_q.push_back(vec);
      end
    end
    for (int x = 0; x < no; x++) begin
      for (int l = 0; l < COL; l++) begin
        v = (relu && m[x][l] < 0) ? 0 : m[x][l];
        vec[l*PB +: PB] = PB'(v);
      end
      exp_q.push_back(vec);
    end
  endtask

  task automatic wait_hi(input string tag, input bit sel);
    int t = 0;
    while (!(sel ? out_valid : in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, VW'(sel ? out_valid : in_ready), VW'(1));
  endtask

  // called at a negedge; returns at the negedge where done is high
  task automatic run_job(input int na_cfg, input int no_cfg,
                         input bit relu, input int n_in,
                         input int n_out, input int stall,
                         input bit poke);
    start       = 1'b1;
    cfg_num_acc = CB'(na_cfg);
    cfg_num_out = NW'(no_cfg);
    cfg_relu    = relu;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", VW'(busy), VW'(1));
    chk("done_low_in_acc", VW'(done), VW'(0));
    for (int i = 0; i < n_in; i++) begin
      wait_hi("in_ready_timeout", 1'b0);
      in_valid = 1'b1;
      in_data  = stim_q.pop_front();
      if (poke && i == 1) begin
        start       = 1'b1;
        cfg_num_acc = CB'(1);
        cfg_num_out = NW'(1);
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
    end
    chk("drain_latency", VW'(out_valid), VW'(1));
    chk("in_ready_drain", VW'(in_ready), VW'(0));
    for (int k = 0; k < n_out; k++) begin
      wait_hi("out_valid_timeout", 1'b1);
      if (k == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_valid", VW'(out_valid), VW'(1));
          chk("stall_data", out_data, exp_q[0]);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      chk("drain_pixel", out_data, exp_q.pop_front());
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("done_pulse", VW'(done), VW'(1));
    chk("idle_valid", VW'(out_valid), VW'(0));
    chk("idle_data", out_data, VW'(0));
    chk("idle_busy", VW'(busy), VW'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    cfg_num_acc = '0;
    cfg_num_out = '0;
    cfg_relu    = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_data", out_data, VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    reset = 1'b0;
    @(negedge clk);

    // 3 passes x 4 pixels of +5
    repeat (12) stim_q.push_back(fill(5));
    repeat (4) exp_q.push_back(fill(15));
    run_job(3, 4, 1'b0, 12, 4, 0, 1'b0);

    // ReLU clamps the negative pixel; starts back-to-back
    stim_q.push_back(fill(-7));
    stim_q.push_back(fill(3));
    stim_q.push_back(fill(2));
    stim_q.push_back(fill(4));
    exp_q.push_back(fill(0));
    exp_q.push_back(fill(7));
    run_job(2, 2, 1'b1, 4, 2, 0, 1'b0);

    // saturation both ways
    repeat (2) stim_q.push_back(fill(30000));
    exp_q.push_back(fill(32767));
    run_job(2, 1, 1'b0, 2, 1, 0, 1'b0);
    repeat (2) stim_q.push_back(fill(-30000));
    exp_q.push_back(fill(-32768));
    run_job(2, 1, 1'b0, 2, 1, 0, 1'b0);

    // backpressure on first drain beat
    gen_rand(2, 3, 1'b0);
    run_job(2, 3, 1'b0, 6, 3, 5, 1'b0);

    // zero config behaves as 1/1
    gen_rand(1, 1, 1'b0);
    run_job(0, 0, 1'b0, 1, 1, 0, 1'b0);

    // oversize num_out clamps to depth
    gen_rand(1, DEPTH, 1'b1);
    run_job(1, DEPTH + 5, 1'b1, DEPTH, DEPTH, 0, 1'b0);

    // start during ACC is ignored
    gen_rand(2, 2, 1'b0);
    run_job(2, 2, 1'b0, 4, 2, 0, 1'b1);

    // abort after 3 of 8 beats
    @(negedge clk);
    start       = 1'b1;
    cfg_num_acc = CB'(2);
    cfg_num_out = NW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = fill(1000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_in_ready", VW'(in_ready), VW'(0));
    chk("abort_out_valid", VW'(out_valid), VW'(0));
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", VW'(done), VW'(0));
      @(negedge clk);
    end
    for (int x = 1; x <= 4; x++) stim_q.push_back(fill(x));
    for (int x = 1; x <= 4; x++) stim_q.push_back(fill(10 * x));
    for (int x = 1; x <= 4; x++) exp_q.push_back(fill(11 * x));
    run_job(2, 4, 1'b0, 8, 4, 0, 1'b0);

    @(negedge clk);
    chk("done_single_cycle", VW'(done), VW'(0));
    chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
    chk("stimulus_empty", VW'(stim_q.size()), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_acc_array.md
Name: sfp_acc_array

Overview:
Parametrised successor to the per-column SFP stage that sits between the OFIFO read port and psum memory write-back. It accumulates `num_acc` partial-sum passes per output pixel, for `col` channels, in an internal `depth`-entry buffer. It then drains the finished pixels with optional ReLU over a valid/ready stream. This removes the external read-modify-write traffic through PMEM per kernel tap.

Parameters:
col, 8, number of psum lanes (one per MAC column)
psum_bw, 16, signed width of each lane, input and output
depth, 16, number of output pixels held in the accumulation buffer
cnt_bw, 8, width of the pass-count configuration

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches cfg_* and begins a job (honoured in IDLE only)
cfg_num_acc  input  cnt_bw  passes per pixel; 0 treated as 1
cfg_num_out  input  $clog2(depth)+1  pixels per pass; 0 treated as 1, >depth clamped to depth
cfg_relu  input  1  apply ReLU on drain
in_valid  input  1  psum vector present
in_ready  output  1  block accepts psum vector
in_data  input  psum_bw*col  lane i at [psum_bw*(i+1)-1 : psum_bw*i], signed
out_valid  output  1  finished pixel vector present
out_ready  input  1  consumer accepts
out_data  output  psum_bw*col  finished pixel vector, same lane packing
busy  output  1  high in ACC or DRAIN
done  output  1  one-cycle pulse after last drain beat

Behaviour:
- Reset (synchronous, active-high):
  - state→IDLE; wr_ptr, rd_ptr, pass_cnt → 0.
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Buffer contents are not cleared and are don't-care.
  - Reset mid-job aborts the job; no done pulse is produced.
- States are IDLE, ACC and DRAIN.
- IDLE:
  - start=1 latches effective num_acc / num_out / relu into internal registers and goes to ACC.
  - start is ignored in ACC and DRAIN, and cfg_* changes there have no effect.
- ACC:
  - in_ready=1.
  - A beat is in_valid && in_ready.
  - On a beat:
    - pass_cnt==0: buf[wr_ptr] ← in_data (overwrite, so no prior clear is needed).
    - otherwise: buf[wr_ptr] ← sat(buf[wr_ptr] + in_data), per lane.
  - wr_ptr increments on each beat.
  - At wr_ptr==num_out-1, wr_ptr wraps to 0 and pass_cnt increments.
  - On the final beat (pass_cnt==num_acc-1 && wr_ptr==num_out-1): go to DRAIN, rd_ptr=0.
  - No bubble is required between passes.
- Arithmetic:
  - Per-lane signed add in psum_bw+1 bits, then saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Lanes are independent; no carry between lanes.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - out_data is buf[rd_ptr] per lane, with negative lanes forced to 0 when relu=1. It is combinational from buffer and rd_ptr.
  - out_data must stay stable while out_valid && !out_ready.
  - On out_valid && out_ready, rd_ptr increments.
  - On the last pixel (rd_ptr==num_out-1): next state IDLE, done=1 for exactly that next cycle, out_valid=0.
- out_data=0 whenever out_valid=0.
- First-output latency: DRAIN entry is the cycle after the final input beat.
- Back-to-back jobs: a start in the same cycle done is high is accepted (state is IDLE).
- busy = (state != IDLE).

Decomposition:
- Shared package `sfp_pkg`:
  - state enum {IDLE, ACC, DRAIN};
  - the saturating-add function;
  - the ReLU function.
- Sub-module `sfp_lane_sat` (one lane): combinational saturating add plus ReLU, width psum_bw. It is instantiated col times in a generate loop.
- Buffer, pointers and FSM stay in the top module.

Test Plan:
- num_acc=3, num_out=4, relu=0, col lanes all +5 on every beat → 12 beats, then 4 drain beats each with all lanes = 15; done one cycle after the 4th drain beat.
- num_acc=2, num_out=2, relu=1; pixel0 lanes -7 then +2; pixel1 lanes +3 then +4 → drain pixel0 = 0 (sum -5 clamped), pixel1 = 7.
- Saturation, psum_bw=16, num_acc=2, num_out=1: +30000 then +30000 → 32767; -30000 then -30000 → -32768 with relu=0.
- Drain with out_ready held low 5 cycles → out_data constant and out_valid high throughout; rd_ptr does not advance; then full drain completes normally.
- Config edge cases:
  - cfg_num_acc=0, cfg_num_out=0 → behaves as 1/1: one input beat, one output beat.
  - cfg_num_out=depth+5 → depth input beats per pass.
  - start pulsed during ACC → ignored; job length unchanged.
- Reset asserted mid-ACC (after 3 of 8 beats) → next cycle busy=0, in_ready=0, out_valid=0, no done; a new job afterwards produces correct sums with no residue from the aborted job.
